// File: rtl/dma_pkg.sv
// Shared widths and fetch-state encoding for the DMA read engine.
// Imported by dma_reader and dma_rd_fifomem.
package dma_pkg;

    localparam int DMA_LEN_W  = 16;
    localparam int DMA_ADDR_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/dma_rd_fifomem.sv
// Word storage for the DMA read FIFO.
// Synchronous write port, asynchronous read port.
module dma_rd_fifomem
    import dma_pkg::*;
#(
    parameter int WORDS = 16,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DMA_ADDR_W-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DMA_ADDR_W-1:0] rdata
);

    logic [DMA_ADDR_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dma_reader.sv
// Single-outstanding-read DMA engine feeding a FIFO toward a sink.
// Optional abort input when DMA_READER_ABORT_EN is defined.
module dma_reader
    import dma_pkg::*;
#(
    parameter int FIFO_WORDS = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DMA_ADDR_W-1:0] src_addr,
    input  logic [DMA_LEN_W-1:0]  len,
    input  logic                  run,
`ifdef DMA_READER_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  done,
    output logic [DMA_ADDR_W-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [DMA_ADDR_W-1:0] mem_data,
    input  logic                  mem_rdy,
    output logic [DMA_ADDR_W-1:0] dst_data,
    output logic                  dst_valid,
    input  logic                  dst_ack
);

    localparam int AW = $clog2(FIFO_WORDS);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_WORDS);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [DMA_LEN_W-1:0] LEN_ONE = DMA_LEN_W'(1);

    fetch_state_t         state;
    logic [DMA_LEN_W-1:0] words_left_mem;
    logic [DMA_LEN_W-1:0] words_left_dst;
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [AW:0]          occ;
    logic                 rd_hit;
    logic                 push;
    logic                 pop;
    logic                 start;
    logic                 unused_bits;

    assign unused_bits = ^src_addr[1:0];
    assign occ         = wr_ptr - rd_ptr;
    assign done        = (words_left_dst == '0);
    assign dst_valid   = (occ != '0);
    assign pop         = dst_valid && dst_ack;
    assign rd_hit      = (state == REQ) && mem_rdy;
    assign start       = done && run;

`ifdef DMA_READER_ABORT_EN
    logic abort_pend;
    logic kill;

    // In REQ the outstanding read must land before the engine can stop.
    assign kill = ((state == IDLE) && abort)
               || (rd_hit && (abort || abort_pend));
    assign push = rd_hit && !kill;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            abort_pend <= 1'b0;
        end else if (kill) begin
            abort_pend <= 1'b0;
        end else if ((state == REQ) && abort) begin
            abort_pend <= 1'b1;
        end
    end
`else
    assign push = rd_hit;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            mem_rd         <= 1'b0;
            mem_addr       <= '0;
            words_left_mem <= '0;
            words_left_dst <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
`ifdef DMA_READER_ABORT_EN
        end else if (kill) begin
            state          <= IDLE;
            mem_rd         <= 1'b0;
            words_left_mem <= '0;
            words_left_dst <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
`endif
        end else begin
            if (done) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            end

            if (start) begin
                mem_addr       <= {src_addr[31:2], 2'b00};
                words_left_mem <= len;
                words_left_dst <= len;
            end else begin
                if (push) begin
                    words_left_mem <= words_left_mem - LEN_ONE;
                    mem_addr[31:2] <= mem_addr[31:2] + 30'd1;
                end
                if (pop) begin
                    words_left_dst <= words_left_dst - LEN_ONE;
                end
            end

            // A fresh start goes straight to REQ so the first read
            // issues in the cycle right after acceptance.
            case (state)
                IDLE: begin
                    if ((words_left_mem != '0 && occ < DEPTH)
                        || (start && len != '0)) begin
                        state  <= REQ;
                        mem_rd <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_rdy) begin
                        state  <= IDLE;
                        mem_rd <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_rd <= 1'b0;
                end
            endcase
        end
    end

    dma_rd_fifomem #(
        .WORDS (FIFO_WORDS)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (mem_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (dst_data)
    );

endmodule

// File: tb/tb_dma_reader.sv
// Randomized self-checking bench for dma_reader with a queue-based model.
// Abort scenario compiled in when DMA_READER_ABORT_EN is defined.
module tb_dma_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] src_addr;
    logic [15:0] len;
    logic        run;
    logic        abort;
    logic        done;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_data;
    logic        mem_rdy;
    logic [31:0] dst_data;
    logic        dst_valid;
    logic        dst_ack;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_base = '0;
    logic [31:0] exp_q[$];
    int reads = 0;
    int pops = 0;
    int rd_cycles = 0;
    int lat_min = 1;
    int lat_max = 1;
    int cur_lat = 1;
    int ack_mode = 1;
    bit mem_en = 1'b1;

    always #5 clk = ~clk;

    dma_reader #(.FIFO_WORDS(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .src_addr  (src_addr),
        .len       (len),
        .run       (run),
`ifdef DMA_READER_ABORT_EN
        .abort     (abort),
`endif
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_rdy   (mem_rdy),
        .dst_data  (dst_data),
        .dst_valid (dst_valid),
        .dst_ack   (dst_ack)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]} + 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // Memory: answers each read after cur_lat cycles.
    initial begin
        int wait_cnt;
        bit prev_rd;
        logic [31:0] prev_addr;
        wait_cnt = 0;
        prev_rd = 1'b0;
        prev_addr = '0;
        mem_rdy = 1'b0;
        mem_data = '0;
        forever begin
            @(negedge clk);
            mem_rdy = 1'b0;
            if (mem_rd) rd_cycles++;
            if (mem_rd && mem_en) begin
                if (prev_rd) check("addr_stable", mem_addr, prev_addr);
                if (wait_cnt >= cur_lat) begin
                    check("addr", mem_addr, exp_base + 32'(reads) * 4);
                    mem_rdy = 1'b1;
                    mem_data = mem_word(mem_addr);
                    reads++;
                    wait_cnt = 0;
                    prev_rd = 1'b0;
                    cur_lat = $urandom_range(lat_max, lat_min);
                end else begin
                    wait_cnt++;
                    prev_rd = 1'b1;
                    prev_addr = mem_addr;
                end
            end else begin
                wait_cnt = 0;
                prev_rd = 1'b0;
            end
        end
    end

    // Sink: chooses dst_ack, checks each word it consumes.
    initial begin
        dst_ack = 1'b0;
        forever begin
            @(negedge clk);
            case (ack_mode)
                0: dst_ack = 1'b0;
                1: dst_ack = 1'b1;
                default: dst_ack = 1'($urandom_range(1, 0));
            endcase
            if (dst_valid && dst_ack) begin
                if (exp_q.size() > 0) check("data", dst_data, exp_q.pop_front());
                pops++;
            end
        end
    end

    task automatic start_xfer(input logic [31:0] src, input logic [15:0] n,
                              input int lmin, input int lmax, input int amode);
        @(negedge clk); #1;
        lat_min = lmin;
        lat_max = lmax;
        cur_lat = $urandom_range(lmax, lmin);
        ack_mode = amode;
        exp_base = {src[31:2], 2'b00};
        reads = 0;
        pops = 0;
        rd_cycles = 0;
        exp_q.delete();
        for (int i = 0; i < int'(n); i++) exp_q.push_back(mem_word(exp_base + 32'(i) * 4));
        src_addr = src;
        len = n;
        run = 1'b1;
        @(negedge clk); #1;
        run = 1'b0;
        if (n != 0) check("first_rd", 32'(mem_rd), 32'd1);
    endtask

    task automatic wait_done(input int n);
        int c;
        c = 0;
        while (!done && c < 3000) begin
            @(negedge clk); #1;
            c++;
        end
        check("done", 32'(done), 32'd1);
        check("reads", 32'(reads), 32'(n));
        check("pops", 32'(pops), 32'(n));
    endtask

    initial begin
        int c;
        int n;
        reset_n = 1'b0;
        src_addr = '0;
        len = '0;
        run = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_done", 32'(done), 32'd1);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_valid", 32'(dst_valid), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        reset_n = 1'b1;

        // Unaligned source, unit latency, sink always ready.
        start_xfer(32'h0000_1003, 16'd3, 1, 1, 1);
        wait_done(3);

        // Zero-length request stays idle.
        start_xfer(32'h0000_0100, 16'd0, 1, 1, 1);
        check("len0_done", 32'(done), 32'd1);
        repeat (10) @(negedge clk);
        #1;
        check("len0_rd", 32'(rd_cycles), 32'd0);
        check("len0_done2", 32'(done), 32'd1);

        // Address wrap past the top of memory.
        start_xfer(32'hFFFF_FFF8, 16'd4, 0, 2, 1);
        wait_done(4);

        // Back-pressure: FIFO fills, reads stop, then resume.
        start_xfer(32'h0000_8000, 16'd40, 0, 2, 0);
        repeat (120) @(negedge clk);
        #1;
        check("full_reads", 32'(reads), 32'd16);
        check("full_rd", 32'(mem_rd), 32'd0);
        check("full_valid", 32'(dst_valid), 32'd1);
        ack_mode = 1;
        wait_done(40);

        // Reset while a read is pending.
        start_xfer(32'h0000_4000, 16'd8, 1, 1, 1);
        c = 0;
        while (reads < 3 && c < 200) begin @(negedge clk); #1; c++; end
        mem_en = 1'b0;
        c = 0;
        while (!mem_rd && c < 200) begin @(negedge clk); #1; c++; end
        check("mid_rd", 32'(mem_rd), 32'd1);
        reset_n = 1'b0;
        @(negedge clk); #1;
        check("mid_rst_rd", 32'(mem_rd), 32'd0);
        check("mid_rst_done", 32'(done), 32'd1);
        check("mid_rst_valid", 32'(dst_valid), 32'd0);
        reset_n = 1'b1;
        mem_en = 1'b1;
        start_xfer(32'h0000_5004, 16'd5, 0, 3, 2);
        wait_done(5);

`ifdef DMA_READER_ABORT_EN
        start_xfer(32'h0000_2000, 16'd8, 3, 3, 0);
        c = 0;
        while (reads < 2 && c < 200) begin @(negedge clk); #1; c++; end
        c = 0;
        while (!mem_rd && c < 200) begin @(negedge clk); #1; c++; end
        abort = 1'b1;
        @(negedge clk); #1;
        abort = 1'b0;
        c = 0;
        while (reads < 3 && c < 200) begin @(negedge clk); #1; c++; end
        @(negedge clk); #1;
        check("abort_rd", 32'(mem_rd), 32'd0);
        check("abort_done", 32'(done), 32'd1);
        check("abort_valid", 32'(dst_valid), 32'd0);
        c = 0;
        repeat (6) begin
            @(negedge clk); #1;
            if (dst_valid || mem_rd) c++;
        end
        check("abort_quiet", 32'(c), 32'd0);
        exp_q.delete();
        ack_mode = 1;
`endif

        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(50, 1);
            start_xfer($urandom, 16'(n), 0, $urandom_range(3, 0), 2);
            wait_done(n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_reader.md
DMA_READER -- requirements
Module: dma_reader

Interface
REQ-001 SHALL have parameter FIFO_WORDS, default 16, meaning buffer depth in 32-bit words (power of two, 4..512).
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port src_addr  input  32  source byte address; bits [1:0] ignored.
REQ-005 SHALL have port len  input  16  transfer length in words.
REQ-006 SHALL have port run  input  1  start request, sampled only while idle.
REQ-007 SHALL have port done  output  1  high when idle, i.e. all words delivered to sink.
REQ-008 SHALL have port mem_addr  output  32  word-aligned read address, bits [1:0] always 0.
REQ-009 SHALL have port mem_rd  output  1  read request, held until accepted.
REQ-010 SHALL have port mem_data  input  32  read data, valid in the mem_rdy cycle.
REQ-011 SHALL have port mem_rdy  input  1  read completion strobe.
REQ-012 SHALL have port dst_data  output  32  FIFO head word.
REQ-013 SHALL have port dst_valid  output  1  dst_data valid (FIFO non-empty).
REQ-014 SHALL have port dst_ack  input  1  sink consumes head word when high with dst_valid.

Function
REQ-015 SHALL keep two registered 16-bit counters: words_left_mem (reads not yet completed) and words_left_dst (words not yet consumed); done = (words_left_dst == 0).
REQ-016 SHALL, when done and run are both high, latch mem_addr = {src_addr[31:2],2'b00} and load both counters with len; len=0 leaves the block idle.
REQ-017 SHALL ignore run while not done.
REQ-018 SHALL run the fetch FSM with states IDLE and REQ; IDLE->REQ when words_left_mem!=0 and FIFO occupancy < FIFO_WORDS; REQ->IDLE on mem_rdy.
REQ-019 SHALL drive mem_rd high exactly in REQ; mem_addr SHALL be stable while mem_rd is high.
REQ-020 SHALL, on mem_rdy in REQ: write mem_data to FIFO, decrement words_left_mem, advance mem_addr[31:2] by 1 (modulo 2^30, wrap-around permitted).
REQ-021 SHALL ignore mem_rdy outside REQ.
REQ-022 SHALL give first mem_rd in the cycle after run is accepted; dst_valid SHALL rise the cycle after the mem_rdy that writes the word.
REQ-023 SHALL present dst_data combinationally from the FIFO head; on dst_valid && dst_ack it SHALL pop and decrement words_left_dst.
REQ-024 SHALL support simultaneous push and pop in one cycle, occupancy unchanged.
REQ-025 SHALL never push when full (guaranteed by REQ-018); dst_ack with dst_valid low SHALL be a no-op.
REQ-026 SHALL reset FIFO pointers to 0 whenever done is high.

Reset
REQ-027 SHALL, on reset_n low at a clock edge, set state IDLE, mem_rd=0, mem_addr=0, both counters=0 (done=1), FIFO pointers 0 (dst_valid=0); dst_data undefined.
REQ-028 SHALL abandon any transfer on reset mid-operation without waiting for mem_rdy.

Configuration
REQ-029 SHALL, with DMA_READER_ABORT_EN defined, add input abort (1 bit): in IDLE it forces both counters and FIFO pointers to 0 next cycle; in REQ it waits for mem_rdy, discards that data, then does the same.
REQ-030 SHALL, without DMA_READER_ABORT_EN, have no abort port and no abort logic.

Structure
REQ-031 SHALL place DMA_LEN_W=16, DMA_ADDR_W=32 and the fetch-state enum in shared package dma_pkg.
REQ-032 SHALL implement storage as sub-module dma_rd_fifomem (sync write, async read, 32-bit, FIFO_WORDS deep).

Verification
REQ-033 SHALL cover: src_addr=0x1003, len=3, mem_rdy 1 cycle after each mem_rd, dst_ack tied 1 -> mem_addr 0x1000,0x1004,0x1008; three dst_valid pops in order; done after third pop.
REQ-034 SHALL cover: len=40, FIFO_WORDS=16, dst_ack=0 -> exactly 16 reads then mem_rd stays 0; raising dst_ack -> reads resume; all 40 words delivered.
REQ-035 SHALL cover: len=0 with run=1 -> done stays 1, mem_rd never asserted.
REQ-036 SHALL cover: src_addr=0xFFFFFFF8, len=4 -> mem_addr 0xFFFFFFF8,0xFFFFFFFC,0x00000000,0x00000004.
REQ-037 SHALL cover: reset_n low while mem_rd=1, len=8 after 3 words -> next cycle mem_rd=0, done=1, dst_valid=0; new run works.
REQ-038 SHALL cover (with DMA_READER_ABORT_EN): abort in REQ, mem_rdy 3 cycles later -> mem_rd low after mem_rdy, done=1, no further dst_valid.
